if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_id_reg.sv | 53 +++++
 rtl/if_stage.sv | 141 ++++++++++++++
 tb/tb_if_stage.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared CPU package: opcodes, NOP word, default reset PC and fetch FSM states.
package if_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; hold beats flush, flush beats load.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (hold_i) begin
            instr_d = instr_q;
        end else if (flush_i) begin
            instr_d = NOP_WORD;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, RUN/PEND redirect FSM, IF/ID register.
// Define IF_SKID_BUF_EN to add a 1-entry skid register for decode stalls.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic [31:0] ic_rdata,
    input  logic        ic_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [5:0]  opcode
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] ld_instr, ld_pc4;
    logic        flush, stall_eff;

    assign pc_plus4 = pc_q + 32'd4;
    assign ic_addr  = pc_q;

`ifdef IF_SKID_BUF_EN
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    // No access is in flight while the skid entry is full.
    assign ic_req    = ~rst & ~skid_valid_q;
    assign stall_eff = ic_stall & ~skid_valid_q;
`else
    assign ic_req    = ~rst;
    assign stall_eff = ic_stall;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        flush     = 1'b0;
        ld_instr  = ic_rdata;
        ld_pc4    = pc_plus4;
`ifdef IF_SKID_BUF_EN
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
`endif
        unique case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
`ifdef IF_SKID_BUF_EN
                    skid_valid_d = 1'b0;
`endif
                    if (stall_eff) begin
                        pend_pc_d = redirect_pc;
                        state_d   = PEND;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (stall_eff) begin
                    flush = 1'b1;
`ifdef IF_SKID_BUF_EN
                end else if (skid_valid_q) begin
                    ld_instr = skid_instr_q;
                    ld_pc4   = skid_pc4_q;
                    if (!id_stall) skid_valid_d = 1'b0;
                end else if (id_stall) begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = ic_rdata;
                    skid_pc4_d   = pc_plus4;
                    pc_d         = pc_plus4;
`endif
                end else if (!id_stall) begin
                    pc_d = pc_plus4;
                end
            end
            PEND: begin
                // Data returned here belongs to the abandoned path.
                flush = 1'b1;
                if (redirect_valid) pend_pc_d = redirect_pc;
                if (!ic_stall) begin
                    pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

`ifdef IF_SKID_BUF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_WORD;
            skid_pc4_q   <= 32'h0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end
`endif

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (id_stall),
        .flush_i (flush),
        .instr_i (ld_instr),
        .pc4_i   (ld_pc4),
        .instr_o (ifid_instr),
        .pc4_o   (ifid_pc4),
        .valid_o (ifid_valid)
    );

    assign opcode = ifid_instr[31:26];

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with an IF/ID expectation queue.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic [31:0] ic_rdata;
    logic        ic_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [5:0]  opcode;

    typedef struct {
        logic        v;
        logic [31:0] i;
        logic [31:0] p;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_rdata       (ic_rdata),
        .ic_stall       (ic_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .ifid_instr     (ifid_instr),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid),
        .opcode         (opcode)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // One clock: drive, check fetch outputs, push expected IF/ID,
    // step the edge, then pop and compare.
    task automatic cyc(input string tag, input logic r, input logic rv,
                       input logic [31:0] rpc, input logic ics,
                       input logic ids, input logic [31:0] rd,
                       input bit ca, input logic [31:0] ea,
                       input logic er, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep);
        exp_t e;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        ic_stall       = ics;
        id_stall       = ids;
        ic_rdata       = rd;
        #1;
        chk({tag, ".req"}, {31'h0, ic_req}, {31'h0, er});
        if (ca) chk({tag, ".addr"}, ic_addr, ea);
        sb.push_back('{v: ev, i: ei, p: ep});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, e.v});
        chk({tag, ".instr"}, ifid_instr, e.i);
        if (e.v) begin
            chk({tag, ".pc4"}, ifid_pc4, e.p);
            chk({tag, ".opc"}, {26'h0, opcode}, {26'h0, e.i[31:26]});
        end
    endtask

    localparam logic [31:0] W1 = 32'h8C01_0004;
    localparam logic [31:0] W2 = 32'h2002_0005;
    localparam logic [31:0] W3 = 32'h0043_1820;
    localparam logic [31:0] W4 = 32'hAC03_0008;
    localparam logic [31:0] W5 = 32'h1000_0003;
    localparam logic [31:0] W6 = 32'h2004_0006;
    localparam logic [31:0] W7 = 32'h0800_0010;
    localparam logic [31:0] W8 = 32'h8C05_000C;
    localparam logic [31:0] W9 = 32'h2006_0007;
    localparam logic [31:0] WA = 32'hAC07_0010;
    localparam logic [31:0] WB = 32'h2008_0009;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    initial begin
        cyc("rst0", 1, 0, 0, 0, 0, W1, 0, 0, 0, 0, 0, 0);
        cyc("rst1", 1, 0, 0, 0, 0, W1, 0, 0, 0, 0, 0, 0);

        cyc("f0", 0, 0, 0, 0, 0, W1, 1, 32'h0, 1, 1, W1, 32'h4);
        chk("f0.lw", {26'h0, opcode}, {26'h0, 6'b100011});
        cyc("f4", 0, 0, 0, 0, 0, W1, 1, 32'h4, 1, 1, W1, 32'h8);

        cyc("st1", 0, 0, 0, 1, 0, BAD, 1, 32'h8, 1, 0, 0, 0);
        cyc("st2", 0, 0, 0, 1, 0, BAD, 1, 32'h8, 1, 0, 0, 0);
        cyc("st3", 0, 0, 0, 1, 0, BAD, 1, 32'h8, 1, 0, 0, 0);
        cyc("st4", 0, 0, 0, 0, 0, W2, 1, 32'h8, 1, 1, W2, 32'hC);
        cyc("fC", 0, 0, 0, 0, 0, W3, 1, 32'hC, 1, 1, W3, 32'h10);

        cyc("rd1", 0, 1, 32'h40, 0, 0, BAD, 1, 32'h10, 1, 0, 0, 0);
        cyc("rd2", 0, 0, 0, 0, 0, W4, 1, 32'h40, 1, 1, W4, 32'h44);

        cyc("pd1", 0, 1, 32'h80, 1, 0, BAD, 1, 32'h44, 1, 0, 0, 0);
        cyc("pd2", 0, 1, 32'h90, 1, 0, BAD, 1, 32'h44, 1, 0, 0, 0);
        cyc("pd3", 0, 0, 0, 0, 0, BAD, 1, 32'h44, 1, 0, 0, 0);
        cyc("pd4", 0, 0, 0, 0, 0, W5, 1, 32'h90, 1, 1, W5, 32'h94);

`ifdef IF_SKID_BUF_EN
        cyc("ids1", 0, 0, 0, 0, 1, W6, 1, 32'h94, 1, 1, W5, 32'h94);
        cyc("ids2", 0, 0, 0, 0, 1, BAD, 0, 0, 0, 1, W5, 32'h94);
        cyc("ids3", 0, 0, 0, 0, 0, BAD, 0, 0, 0, 1, W6, 32'h98);
`else
        cyc("ids1", 0, 0, 0, 0, 1, BAD, 1, 32'h94, 1, 1, W5, 32'h94);
        cyc("ids2", 0, 0, 0, 0, 1, BAD, 1, 32'h94, 1, 1, W5, 32'h94);
        cyc("ids3", 0, 0, 0, 0, 0, W6, 1, 32'h94, 1, 1, W6, 32'h98);
`endif
        cyc("ids4", 0, 0, 0, 0, 0, W7, 1, 32'h98, 1, 1, W7, 32'h9C);

        cyc("rp1", 0, 1, 32'hC0, 1, 0, BAD, 1, 32'h9C, 1, 0, 0, 0);
        cyc("rp2", 1, 0, 0, 1, 0, BAD, 0, 0, 0, 0, 0, 0);
        cyc("rp3", 0, 0, 0, 0, 0, W8, 1, 32'h0, 1, 1, W8, 32'h4);
        cyc("rp4", 0, 0, 0, 0, 0, W9, 1, 32'h4, 1, 1, W9, 32'h8);

        cyc("rh1", 0, 1, 32'h200, 0, 1, BAD, 1, 32'h8, 1, 1, W9, 32'h8);
        cyc("rh2", 0, 0, 0, 0, 0, WA, 1, 32'h200, 1, 1, WA, 32'h204);

        cyc("wr1", 0, 1, 32'hFFFF_FFFC, 0, 0, BAD, 1, 32'h204, 1, 0, 0, 0);
        cyc("wr2", 0, 0, 0, 0, 0, WB, 1, 32'hFFFF_FFFC, 1, 1, WB, 32'h0);
        cyc("wr3", 0, 0, 0, 1, 0, BAD, 1, 32'h0, 1, 0, 0, 0);

        chk("sb.empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
